// File: rtl/mac_dbg_step_gate.sv
// Stream gate between streamer and MAC engine: free-running pass-through in RUN,
// halted or beat-metered in debug. Optional step_done pulse under MAC_DBG_STEP_DONE_IRQ_EN.
module mac_dbg_step_gate #(
    parameter int DATA_WIDTH     = 32,
    parameter int STEP_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      dbg_active_i,
    input  logic                      dbg_step_i,
    input  logic [STEP_CNT_WIDTH-1:0] step_len_i,
    input  logic                      in_valid_i,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    input  logic                      out_ready_i,
    output logic [1:0]                state_o,
    output logic [STEP_CNT_WIDTH-1:0] step_rem_o,
    output logic [31:0]               beat_cnt_o,
    output logic                      step_done_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [STEP_CNT_WIDTH-1:0] rem_q, rem_d;
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [31:0]               cnt_q;
    logic                      gate_open;
    logic                      accept;
    logic                      handshake;

    // Valid/ready: a beat moves on a side exactly in the cycle where that side's
    // valid and ready are both high; valid never depends on ready, and in_ready_o
    // depends only on registered state and out_ready_i, never on in_valid_i.
    assign gate_open  = (state_q == RUN) || (state_q == STEP);
    assign in_ready_o = gate_open && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign handshake  = valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            RUN: begin
                if (dbg_active_i) state_d = HALT;
            end
            HALT: begin
                if (!dbg_active_i) begin
                    state_d = RUN;
                end else if (dbg_step_i) begin
                    state_d = STEP;
                    rem_d   = (step_len_i == '0) ? STEP_CNT_WIDTH'(1) : step_len_i;
                end
            end
            STEP: begin
                if (!dbg_active_i) begin
                    state_d = RUN;
                    rem_d   = '0;
                end else if (accept) begin
                    // rem <= 1 also catches a corrupted zero count so STEP cannot stick.
                    if (rem_q <= STEP_CNT_WIDTH'(1)) begin
                        state_d = HALT;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - STEP_CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= RUN;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (accept) begin
                valid_q <= 1'b1;
                data_q  <= in_data_i;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
            if (handshake) cnt_q <= cnt_q + 32'd1;
        end
    end

`ifdef MAC_DBG_STEP_DONE_IRQ_EN
    logic step_exhaust;
    logic done_q;

    assign step_exhaust = (state_q == STEP) && dbg_active_i && accept &&
                          (rem_q <= STEP_CNT_WIDTH'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) done_q <= 1'b0;
        else                  done_q <= step_exhaust;
    end

    assign step_done_o = done_q;
`else
    assign step_done_o = 1'b0;
`endif

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign state_o     = state_q;
    assign step_rem_o  = rem_q;
    assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_mac_dbg_step_gate.sv
// Self-checking bench for mac_dbg_step_gate: directed debug scenarios plus a random
// phase, all checked each cycle against a queue-based behavioural model.
module tb_mac_dbg_step_gate;

    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_i, clear_i, dbg_active_i, dbg_step_i;
    logic [SW-1:0] step_len_i;
    logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [DW-1:0] in_data_i, out_data_o;
    logic [1:0]    state_o;
    logic [SW-1:0] step_rem_o;
    logic [31:0]   beat_cnt_o;
    logic          step_done_o;

    mac_dbg_step_gate #(.DATA_WIDTH(DW), .STEP_CNT_WIDTH(SW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .dbg_active_i(dbg_active_i), .dbg_step_i(dbg_step_i), .step_len_i(step_len_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .state_o(state_o), .step_rem_o(step_rem_o), .beat_cnt_o(beat_cnt_o),
        .step_done_o(step_done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0=RUN 1=HALT 2=STEP, beats-left budget, queue of
    // accepted beats not yet delivered downstream.
    int            m_mode = 0;
    int            m_rem  = 0;
    logic [31:0]   m_cnt  = 0;
    bit            m_done = 0;
    logic [DW-1:0] exp_q[$];

    int obs_acc  = 0;
    int obs_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        bit exp_ready, acc, hs;
        #1;
        exp_ready = (m_mode != 1) && (exp_q.size() == 0 || out_ready_i);
        check_eq("in_ready", 64'(in_ready_o), 64'(exp_ready));
        check_eq("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq("out_data", 64'(out_data_o), 64'(exp_q[0]));
        check_eq("state", 64'(state_o), 64'(m_mode));
        check_eq("step_rem", 64'(step_rem_o), 64'(m_rem));
        check_eq("beat_cnt", 64'(beat_cnt_o), 64'(m_cnt));
`ifdef MAC_DBG_STEP_DONE_IRQ_EN
        check_eq("step_done", 64'(step_done_o), 64'(m_done));
`else
        check_eq("step_done", 64'(step_done_o), 64'(0));
`endif
        if (in_valid_i && in_ready_o) obs_acc++;
        if (step_done_o) obs_done++;

        acc = in_valid_i && exp_ready;
        hs  = (exp_q.size() != 0) && out_ready_i;
        if (rst_i || clear_i) begin
            exp_q.delete();
            m_mode = 0; m_rem = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (hs) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (acc) exp_q.push_back(in_data_i);
            if (m_mode == 0) begin
                if (dbg_active_i) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!dbg_active_i) m_mode = 0;
                else if (dbg_step_i) begin
                    m_mode = 2;
                    m_rem  = (step_len_i == 0) ? 1 : int'(step_len_i);
                end
            end else begin
                if (!dbg_active_i) begin
                    m_mode = 0; m_rem = 0;
                end else if (acc) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_mode = 1; m_done = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        in_data_i = $urandom;
    endtask

    task automatic idle_inputs();
        rst_i = 0; clear_i = 0; dbg_step_i = 0; in_valid_i = 0; out_ready_i = 1;
    endtask

    initial begin
        rst_i = 1; clear_i = 0; dbg_active_i = 0; dbg_step_i = 0; step_len_i = 0;
        in_valid_i = 0; in_data_i = 0; out_ready_i = 0;
        @(posedge clk);
        #1;
        tick();
        tick();
        idle_inputs();
        check_eq("rst_state", 64'(state_o), 64'(0));
        check_eq("rst_valid", 64'(out_valid_o), 64'(0));
        check_eq("rst_cnt", 64'(beat_cnt_o), 64'(0));

        // Run passthrough
        in_valid_i = 1;
        for (int i = 0; i < 100; i++) tick();
        in_valid_i = 0;
        tick();
        check_eq("pass_cnt", 64'(beat_cnt_o), 64'(100));

        // Halt with a live stream
        in_valid_i = 1; out_ready_i = 0;
        tick();
        dbg_active_i = 1;
        tick();
        check_eq("halt_state", 64'(state_o), 64'(1));
        check_eq("halt_ready", 64'(in_ready_o), 64'(0));
        out_ready_i = 1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("halt_drained", 64'(out_valid_o), 64'(0));

        // Step of 3
        step_len_i = 3; dbg_step_i = 1; in_valid_i = 0;
        tick();
        dbg_step_i = 0; in_valid_i = 1;
        obs_acc = 0; obs_done = 0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("step3_beats", 64'(obs_acc), 64'(3));
        check_eq("step3_state", 64'(state_o), 64'(1));
`ifdef MAC_DBG_STEP_DONE_IRQ_EN
        check_eq("step3_done", 64'(obs_done), 64'(1));
`else
        check_eq("step3_done", 64'(obs_done), 64'(0));
`endif

        // Step length 0 releases one beat
        step_len_i = 0; dbg_step_i = 1; in_valid_i = 0;
        tick();
        dbg_step_i = 0; in_valid_i = 1; obs_acc = 0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("step0_beats", 64'(obs_acc), 64'(1));

        // Second step during STEP is ignored
        step_len_i = 4; dbg_step_i = 1; in_valid_i = 0;
        tick();
        step_len_i = 9;
        tick();
        dbg_step_i = 0; in_valid_i = 1; obs_acc = 0;
        for (int i = 0; i < 12; i++) tick();
        check_eq("step_ign_beats", 64'(obs_acc), 64'(4));
        check_eq("step_ign_state", 64'(state_o), 64'(1));

        // Backpressure in RUN
        dbg_active_i = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready_i = i[0];
            tick();
        end
        out_ready_i = 1; in_valid_i = 0;
        tick(); tick();

        // Abort a step with 5 beats left, then clear with a held beat
        dbg_active_i = 1;
        tick();
        step_len_i = 8; dbg_step_i = 1;
        tick();
        dbg_step_i = 0; in_valid_i = 1;
        for (int i = 0; i < 3; i++) tick();
        in_valid_i = 0;
        check_eq("abort_rem5", 64'(step_rem_o), 64'(5));
        dbg_active_i = 0;
        tick();
        check_eq("abort_state", 64'(state_o), 64'(0));
        check_eq("abort_rem", 64'(step_rem_o), 64'(0));
        in_valid_i = 1; out_ready_i = 0;
        tick();
        in_valid_i = 0;
        check_eq("clr_pre_valid", 64'(out_valid_o), 64'(1));
        clear_i = 1;
        tick();
        clear_i = 0;
        check_eq("clr_valid", 64'(out_valid_o), 64'(0));
        check_eq("clr_cnt", 64'(beat_cnt_o), 64'(0));
        check_eq("clr_state", 64'(state_o), 64'(0));

        // Random phase
        for (int i = 0; i < 2000; i++) begin
            in_valid_i   = ($urandom_range(0, 3) != 0);
            out_ready_i  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) dbg_active_i = ~dbg_active_i;
            dbg_step_i   = ($urandom_range(0, 7) == 0);
            step_len_i   = SW'($urandom_range(0, 6));
            rst_i        = ($urandom_range(0, 299) == 0);
            clear_i      = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
